// File: rtl/noc_pkg.sv
// Shared NoC router constants: port indices, default port count and index-width derivation.
package noc_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  localparam int NOC_PORTS = 5;

  function automatic int requestWidth(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  localparam int NOC_REQUEST_WIDTH = requestWidth(NOC_PORTS);

  typedef enum logic {
    FREE     = 1'b0,
    RESERVED = 1'b1
  } outState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker for one output: the first requester strictly after the last winner wins.
// The pointer is loaded with the winner whenever any request is present.
module rr_arbiter #(
  parameter int PORTS = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] grant,
  output logic [IDX_W-1:0] winIdx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  // First pass looks above the pointer, second pass wraps around to index 0.
  always_comb begin
    grant  = '0;
    winIdx = '0;
    found  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (!found && req[i] && (IDX_W'(i) > ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winIdx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winIdx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(PORTS - 1);
    end else if (found) begin
      ptr <= winIdx;
    end
  end

endmodule

// File: rtl/route_reserve_arbiter.sv
// Router route reservation: each output is FREE or RESERVED by one input, granted round-robin.
// Optional sticky illegal-request flag on err: define ROUTE_RESERVE_ARBITER_ILLEGAL_REQ_EN.
//
//   state    | meaning
//   FREE     | output unowned; candidates arbitrated every cycle
//   RESERVED | output owned by owner[o] until that input pulses rel
module route_reserve_arbiter
  import noc_pkg::*;
#(
  parameter int PORTS         = NOC_PORTS,
  parameter int REQUEST_WIDTH = requestWidth(PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               req_valid,
  input  logic [PORTS*REQUEST_WIDTH-1:0] req_port,
  input  logic [PORTS-1:0]               rel,       // tail-flit route release pulses
  output logic [PORTS-1:0]               grant,
  output logic [PORTS*REQUEST_WIDTH-1:0] out_sel,
  output logic [PORTS-1:0]               out_busy,
  output logic                           err
);

  outState_t                        state [PORTS];
  logic [REQUEST_WIDTH-1:0]         owner [PORTS];
  logic [REQUEST_WIDTH-1:0]         winIdx [PORTS];
  logic [PORTS-1:0][PORTS-1:0]      cand;
  logic [PORTS-1:0][PORTS-1:0]      win;
  logic [PORTS-1:0]                 owns;
  logic [PORTS-1:0]                 relHit;
  logic [PORTS-1:0]                 grantNext;

  always_comb begin
    owns   = '0;
    relHit = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (state[o] == RESERVED && owner[o] == REQUEST_WIDTH'(i)) begin
          owns[i] = 1'b1;
          if (rel[i]) relHit[o] = 1'b1;
        end
      end
    end
  end

  // Out-of-range port indices never match any o, so they are never granted.
  always_comb begin
    cand = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        cand[o][i] = (state[o] == FREE) && req_valid[i] && !owns[i] &&
                     (req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    rr_arbiter #(
      .PORTS (PORTS),
      .IDX_W (REQUEST_WIDTH)
    ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (cand[o]),
      .grant  (win[o]),
      .winIdx (winIdx[o])
    );
  end

  always_comb begin
    grantNext = '0;
    for (int o = 0; o < PORTS; o++) grantNext = grantNext | win[o];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      for (int o = 0; o < PORTS; o++) begin
        state[o] <= FREE;
        owner[o] <= '0;
      end
    end else begin
      grant <= grantNext;
      for (int o = 0; o < PORTS; o++) begin
        case (state[o])
          FREE: begin
            if (|cand[o]) begin
              state[o] <= RESERVED;
              owner[o] <= winIdx[o];
            end
          end
          RESERVED: begin
            if (relHit[o]) begin
              state[o] <= FREE;
              owner[o] <= '0;
            end
          end
          default: state[o] <= FREE;
        endcase
      end
    end
  end

  always_comb begin
    out_busy = '0;
    out_sel  = '0;
    for (int o = 0; o < PORTS; o++) begin
      out_busy[o]                                = (state[o] == RESERVED);
      out_sel[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner[o];
    end
  end

`ifdef ROUTE_RESERVE_ARBITER_ILLEGAL_REQ_EN
  logic illegalReq;

  always_comb begin
    illegalReq = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (req_valid[i] && int'(req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH]) >= PORTS)
        illegalReq = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (illegalReq) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Directed and random checks of route_reserve_arbiter against a behavioural reservation model.
module tb_route_reserve_arbiter;
  import noc_pkg::*;

  localparam int P = NOC_PORTS;
  localparam int W = NOC_REQUEST_WIDTH;
`ifdef ROUTE_RESERVE_ARBITER_ILLEGAL_REQ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [P-1:0]     reqValid;
  logic [P*W-1:0]   reqPort;
  logic [P-1:0]     rel;
  logic [P-1:0]     grant;
  logic [P*W-1:0]   outSel;
  logic [P-1:0]     outBusy;
  logic             err;

  int errors = 0;
  int checks = 0;

  // Reference: per-output reservation record and last winner.
  bit           mBusy  [P];
  int           mOwner [P];
  int           mPtr   [P];
  logic [P-1:0] mGrant;
  logic         mErr;

  route_reserve_arbiter #(.PORTS(P), .REQUEST_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_port  (reqPort),
    .rel       (rel),
    .grant     (grant),
    .out_sel   (outSel),
    .out_busy  (outBusy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int portOf(input int i);
    return int'(reqPort[i*W +: W]);
  endfunction

  task automatic setPort(input int i, input int v);
    reqPort[i*W +: W] = W'(v);
  endtask

  function automatic void modelStep();
    bit           owned [P];
    logic [P-1:0] g;
    int           sel;
    int           idx;
    if (rst) begin
      for (int o = 0; o < P; o++) begin
        mBusy[o] = 0; mOwner[o] = 0; mPtr[o] = P - 1;
      end
      mGrant = '0;
      mErr   = 1'b0;
      return;
    end
    for (int i = 0; i < P; i++) owned[i] = 0;
    for (int o = 0; o < P; o++) if (mBusy[o]) owned[mOwner[o]] = 1;
    g = '0;
    for (int o = 0; o < P; o++) begin
      if (mBusy[o]) begin
        if (rel[mOwner[o]]) begin
          mBusy[o] = 0; mOwner[o] = 0;
        end
      end else begin
        sel = -1;
        for (int k = 1; k <= P; k++) begin
          idx = (mPtr[o] + k) % P;
          if (sel < 0 && reqValid[idx] && portOf(idx) == o && !owned[idx]) sel = idx;
        end
        if (sel >= 0) begin
          mBusy[o] = 1; mOwner[o] = sel; mPtr[o] = sel; g[sel] = 1'b1;
        end
      end
    end
    mGrant = g;
    if (ERR_EN)
      for (int i = 0; i < P; i++) if (reqValid[i] && portOf(i) >= P) mErr = 1'b1;
  endfunction

  task automatic tick();
    logic [P-1:0]   expBusy;
    logic [P*W-1:0] expSel;
    @(posedge clk);
    modelStep();
    #1;
    expBusy = '0;
    expSel  = '0;
    for (int o = 0; o < P; o++) begin
      expBusy[o]       = mBusy[o];
      expSel[o*W +: W] = W'(mOwner[o]);
    end
    check("model_grant", 32'(grant), 32'(mGrant));
    check("model_busy", 32'(outBusy), 32'(expBusy));
    check("model_sel", 32'(outSel), 32'(expSel));
    check("model_err", 32'(err), 32'(mErr));
  endtask

  int order [4];
  int who;

  initial begin
    rst = 1'b1; reqValid = '0; reqPort = '0; rel = '0;
    tick(); tick();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(outBusy), 32'h0);
    check("reset_sel", 32'(outSel), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // Single request, held valid.
    reqValid = 5'b00001; setPort(0, EAST);
    tick();
    check("single_grant", 32'(grant), 32'h01);
    check("single_busy", 32'(outBusy), 32'h04);
    check("single_sel2", 32'(outSel[2*W +: W]), 32'h0);
    tick();
    check("single_held_grant", 32'(grant), 32'h0);
    tick();
    check("single_held_grant2", 32'(grant), 32'h0);
    reqValid = '0; rel = 5'b00001;
    tick();
    rel = '0;
    check("single_released", 32'(outBusy), 32'h0);

    // Parallel reservations on independent outputs.
    reqValid = 5'b10101; reqPort = '0;
    setPort(0, 1); setPort(2, 3); setPort(4, 0);
    tick();
    check("par_grant", 32'(grant), 32'h15);
    check("par_busy", 32'(outBusy), 32'h0B);
    check("par_sel", 32'(outSel), 32'h0404);
    reqValid = '0; rel = 5'b10101;
    tick();
    rel = '0;
    tick();

    // Fairness on output 0 among inputs 1, 3, 4.
    reqValid = 5'b11010; reqPort = '0;
    for (int n = 0; n < 4; n++) begin
      who = -1;
      for (int w = 0; w < 10 && who < 0; w++) begin
        tick();
        for (int i = 0; i < P; i++) if (grant[i]) who = i;
      end
      check("fair_grant_seen", 32'(who >= 0), 32'h1);
      order[n] = who;
      tick(); tick();
      if (n == 3) reqValid = '0;
      if (who >= 0) rel[who] = 1'b1;
      tick();
      rel = '0;
    end
    check("fair_order0", 32'(order[0]), 32'd1);
    check("fair_order1", 32'(order[1]), 32'd3);
    check("fair_order2", 32'(order[2]), 32'd4);
    check("fair_order3", 32'(order[3]), 32'd1);
    tick();

    // Release colliding with a new request for the same output.
    reqValid = 5'b00100; reqPort = '0; setPort(2, WEST);
    tick();
    check("coll_owner_grant", 32'(grant), 32'h04);
    reqValid = '0;
    tick();
    rel = 5'b00100; reqValid = 5'b00001; setPort(0, WEST);
    tick();
    rel = '0;
    check("coll_busy_fall", 32'(outBusy[4]), 32'h0);
    check("coll_no_grant", 32'(grant), 32'h0);
    tick();
    check("coll_grant", 32'(grant), 32'h01);
    check("coll_busy_rise", 32'(outBusy[4]), 32'h1);
    reqValid = '0; rel = 5'b00001;
    tick();
    rel = '0;

    // Illegal output index.
    reqValid = 5'b01000; reqPort = '0; setPort(3, 6);
    tick();
    check("illegal_grant", 32'(grant), 32'h0);
    check("illegal_err", 32'(err), 32'(ERR_EN));
    tick();
    check("illegal_grant2", 32'(grant), 32'h0);
    check("illegal_busy", 32'(outBusy), 32'h0);
    reqValid = '0;
    tick();

    // Reset in the middle of reservations.
    reqValid = 5'b00011; reqPort = '0; setPort(0, 1); setPort(1, 3);
    tick();
    check("pre_rst_busy", 32'(outBusy), 32'h0A);
    reqValid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(outBusy), 32'h0);
    check("rst_sel", 32'(outSel), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reqValid = 5'b00101; reqPort = '0; setPort(0, 1); setPort(2, 1);
    tick();
    check("post_rst_grant", 32'(grant), 32'h01);
    check("post_rst_busy", 32'(outBusy), 32'h02);
    check("post_rst_sel1", 32'(outSel[1*W +: W]), 32'h0);
    reqValid = '0; rel = 5'b00001;
    tick();
    rel = '0;

    // Random traffic, including illegal indices, stray releases and resets.
    for (int n = 0; n < 400; n++) begin
      reqValid = P'($urandom);
      for (int i = 0; i < P; i++) setPort(i, int'($urandom_range(0, (1 << W) - 1)));
      rel = P'($urandom & $urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; reqValid = '0; rel = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/route_reserve_arbiter.md
ROUTE_RESERVE_ARBITER -- requirements
Module: route_reserve_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 5: number of router input and output ports.
REQ-002 SHALL have parameter REQUEST_WIDTH, default 3: width of one output-port index; SHALL satisfy 2^REQUEST_WIDTH >= PORTS.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  PORTS  bit i: input port i holds a head flit and requests an output route.
REQ-006 req_port  input  PORTS*REQUEST_WIDTH  slice i: output index requested by input i.
REQ-007 release  input  PORTS  bit i: one-cycle pulse; input i has forwarded its tail flit and frees its route.
REQ-008 grant  output  PORTS  bit i: one-cycle pulse; input i's route is reserved (drives routeReserveStatus of port i).
REQ-009 out_sel  output  PORTS*REQUEST_WIDTH  slice o: input index connected to output o; 0 when output o is free.
REQ-010 out_busy  output  PORTS  bit o: output o is reserved.
REQ-011 err  output  1  sticky illegal-request flag (see Configuration).

Function
REQ-012 Each output o SHALL hold a two-state FSM: FREE, RESERVED(owner).
REQ-013 In FREE, candidates for o SHALL be inputs i with req_valid[i]=1, req_port[i]=o, and i owning no output.
REQ-014 Among candidates, the winner SHALL be chosen round-robin: first candidate at index strictly after rr_ptr[o], wrapping PORTS-1 to 0.
REQ-015 Grant SHALL be registered: requests sampled at edge k yield grant[winner]=1 and out_busy[o]=1 during cycle k+1.
REQ-016 grant[i] SHALL be high for exactly one cycle per reservation, even if req_valid[i] stays high afterwards.
REQ-017 On a grant, rr_ptr[o] SHALL be loaded with the winner index; otherwise rr_ptr[o] SHALL hold.
REQ-018 In RESERVED, further requests for o SHALL be stalled (no grant) until released.
REQ-019 release[i] with i owning o SHALL return o to FREE at the next edge; out_busy[o]=0 and out_sel[o]=0 from the following cycle.
REQ-020 release and a competing request for the same output in the same cycle: release SHALL take effect; the new grant SHALL occur no earlier than one cycle after out_busy[o] falls.
REQ-021 release[i] with i owning nothing SHALL be ignored.
REQ-022 Independent outputs SHALL grant in the same cycle to distinct inputs; at most one grant bit per input per cycle.
REQ-023 Requests with req_port[i] >= PORTS SHALL never be granted.

Reset
REQ-024 rst SHALL set all outputs FREE, grant=0, out_busy=0, out_sel=0, err=0, every rr_ptr[o]=PORTS-1 (so input 0 wins first).
REQ-025 rst asserted mid-reservation SHALL drop every reservation immediately; no grant pulse in the cycle after reset deassertion.

Configuration
REQ-026 Macro ROUTE_RESERVE_ARBITER_ILLEGAL_REQ_EN, defined: err SHALL set one cycle after any req_valid[i]=1 with req_port[i] >= PORTS and hold until rst.
REQ-027 Macro undefined: err SHALL be tied 0; no detection logic synthesized; REQ-023 still holds.

Structure
REQ-028 Shared package noc_pkg SHALL hold the port-index constants (LOCAL, NORTH, EAST, SOUTH, WEST), PORTS default, and the REQUEST_WIDTH derivation; this block SHALL import it.
REQ-029 A sub-module rr_arbiter (PORTS-wide request vector in, one-hot winner out, registered pointer) SHALL be instantiated once per output.

Verification (PORTS=5, REQUEST_WIDTH=3)
REQ-030 Single: req_valid=00001, req_port[0]=2 -> next cycle grant=00001, out_busy=00100, out_sel[2]=0; grant low thereafter while valid held.
REQ-031 Fairness: inputs 1,3,4 all request output 0 continuously, each releasing 3 cycles after its grant -> grant order 1,3,4,1, no input starved.
REQ-032 Release/request collision: input 2 owns output 4, release[2] same cycle input 0 requests 4 -> out_busy[4] falls next cycle, grant[0] one cycle later.
REQ-033 Parallel: inputs 0->1, 2->3, 4->0 requested together -> grant=10101 in one cycle, out_busy=01011.
REQ-034 Illegal: req_port[3]=6 with valid -> never granted; err=1 next cycle with macro defined, err=0 without.
REQ-035 Reset mid-operation: outputs 1 and 3 reserved, rst for one cycle -> out_busy=0, out_sel=0, grant=0; first post-reset contention on output 1 by inputs 0 and 2 grants input 0.
